// File: rtl/xbar_slave_arbiter.sv
// Per-slave round-robin arbiter/router for the 2x2 crossbar.
// Optional watchdog enabled by defining XBAR_ARB_TIMEOUT_EN.
module xbar_slave_arbiter #(
  parameter int MASTERS  = 2,
  parameter int N        = 32,
  parameter int SLAVE_ID = 0,
  parameter int SEL_BIT  = N - 1,
  parameter int TIMEOUT  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [MASTERS-1:0]   m_req,
  input  logic [MASTERS*N-1:0] m_addr,
  input  logic [MASTERS-1:0]   m_cmd,
  input  logic [MASTERS*N-1:0] m_wdata,
  output logic [MASTERS-1:0]   m_ack,
  output logic [MASTERS*N-1:0] m_rdata,
  output logic                 s_req,
  output logic [N-1:0]         s_addr,
  output logic                 s_cmd,
  output logic [N-1:0]         s_wdata,
  input  logic                 s_ack,
  input  logic [N-1:0]         s_rdata,
  output logic [MASTERS-1:0]   grant,
  output logic                 timeout_err
);

  // Handshake: a transaction completes in any cycle where s_req && s_ack;
  // the granted master holds addr/cmd/wdata stable until then.

  localparam int PW = (MASTERS > 1) ? $clog2(MASTERS) : 1;

  typedef enum logic {ST_IDLE, ST_BUSY} state_e;

  state_e             state_q;
  logic [MASTERS-1:0] grant_q;
  logic [PW-1:0]      ptr_q;

  logic [MASTERS-1:0] elig;
  logic               pick_found;
  logic [PW-1:0]      pick_idx;
  logic [PW-1:0]      cand_idx;
  logic [PW-1:0]      g_idx;
  logic               busy;
  logic               done;
  int                 cand;

  always_comb begin
    for (int i = 0; i < MASTERS; i++) begin
      elig[i] = m_req[i] && (m_addr[i*N+SEL_BIT] == 1'(SLAVE_ID));
    end
  end

  // Scan in reverse so the last hit is the one nearest to ptr+1.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int k = MASTERS; k >= 1; k--) begin
      cand     = (int'(ptr_q) + k) % MASTERS;
      cand_idx = PW'(cand);
      if (elig[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    g_idx = '0;
    for (int i = 0; i < MASTERS; i++) begin
      if (grant_q[i]) g_idx = PW'(i);
    end
  end

  assign busy  = (state_q == ST_BUSY);
  assign s_req = busy && |(grant_q & elig);
  assign done  = s_req && s_ack;
  assign grant = grant_q;

  always_comb begin
    s_addr  = '0;
    s_cmd   = 1'b0;
    s_wdata = '0;
    m_ack   = '0;
    m_rdata = '0;
    for (int i = 0; i < MASTERS; i++) begin
      if (busy && grant_q[i]) begin
        s_addr  = m_addr[i*N +: N];
        s_cmd   = m_cmd[i];
        s_wdata = m_wdata[i*N +: N];
        if (done) begin
          m_ack[i]         = 1'b1;
          m_rdata[i*N +: N] = s_rdata;
        end
      end
    end
  end

`ifdef XBAR_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [CW-1:0] cnt_q;
  logic          tmo_q;
  assign timeout_err = tmo_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= PW'(MASTERS - 1);
`ifdef XBAR_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
`ifdef XBAR_ARB_TIMEOUT_EN
      tmo_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (pick_found) begin
            grant_q <= {{(MASTERS-1){1'b0}}, 1'b1} << pick_idx;
            state_q <= ST_BUSY;
`ifdef XBAR_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        ST_BUSY: begin
          if (done) begin
            ptr_q   <= g_idx;
            grant_q <= '0;
            state_q <= ST_IDLE;
          end else if (!s_req) begin
            // Master withdrew: abort without moving the priority pointer.
            grant_q <= '0;
            state_q <= ST_IDLE;
          end
`ifdef XBAR_ARB_TIMEOUT_EN
          else if (cnt_q == CW'(TIMEOUT - 1)) begin
            ptr_q   <= g_idx;
            grant_q <= '0;
            state_q <= ST_IDLE;
            tmo_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
`endif
        end
        default: begin
          grant_q <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/xbar_slave_arbiter.md
Name: xbar_slave_arbiter

Overview:
- Per-slave-port arbiter and router for the 2x2 master/slave crossbar; one instance sits in front of each slave.
- Selects one of MASTERS requesters whose address targets this slave, using round-robin priority.
- Holds the grant until the slave acks the transaction.
- Muxes the granted master's req/addr/cmd/wdata to the slave and routes ack/rdata back to that master only.

Parameters:
- MASTERS, 2, number of requesting masters (2..8).
- N, 32, address and data width.
- SLAVE_ID, 0, value of the address select bit that targets this slave.
- SEL_BIT, N-1, address bit index used for slave decode.
- TIMEOUT, 16, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- m_req  in  MASTERS  per-master request.
- m_addr  in  MASTERS*N  flattened addresses, master i at [i*N +: N].
- m_cmd  in  MASTERS  per-master command, 1=write, 0=read.
- m_wdata  in  MASTERS*N  flattened write data.
- m_ack  out  MASTERS  per-master ack, one-hot or zero.
- m_rdata  out  MASTERS*N  flattened read data.
- s_req  out  1  request to slave.
- s_addr  out  N  address to slave.
- s_cmd  out  1  command to slave.
- s_wdata  out  N  write data to slave.
- s_ack  in  1  slave ack.
- s_rdata  in  N  slave read data.
- grant  out  MASTERS  one-hot current owner, 0 when idle.
- timeout_err  out  1  watchdog pulse.

Behaviour:
- Eligible request: elig[i] = m_req[i] && (m_addr[i*N+SEL_BIT] == SLAVE_ID).
- FSM states IDLE and BUSY.
- Registered state: grant, last-granted pointer ptr, state.
- Reset (rst=0, async): state=IDLE, grant=0, ptr=MASTERS-1 (master 0 has highest priority first), counter=0.
- All outputs are 0 while in reset: s_req, s_addr, s_cmd, s_wdata, m_ack, m_rdata, grant, timeout_err.
- IDLE:
  - If any elig bit is set, choose the first set bit scanning ptr+1, ptr+2, ... modulo MASTERS.
  - Register a one-hot grant and go to BUSY.
  - If no elig bit is set, stay in IDLE.
- BUSY, combinational outputs from the granted master g:
  - s_req = elig[g].
  - s_addr, s_cmd and s_wdata come from master g.
- Latency: m_req rising edge to s_req is 1 cycle, then 0 cycles from grant to s_req.
- Completion in BUSY: when s_req && s_ack:
  - m_ack[g]=s_ack and m_rdata[g]=s_rdata, combinational in the same cycle.
  - Next cycle: ptr=g, grant=0, state=IDLE.
  - s_req is therefore low for at least 1 cycle between consecutive transactions.
- Zero-wait slave: s_ack may be high in the first BUSY cycle; it completes that cycle.
- Abort: if elig[g] drops in BUSY without an ack, return to IDLE next cycle.
  - No ack is forwarded and ptr is unchanged.
- Non-granted masters: m_ack=0 and m_rdata=0.
- When not BUSY, s_addr, s_cmd and s_wdata are 0.
- s_ack while IDLE is ignored; no m_ack is driven.
- Simultaneous eligible requests are resolved strictly by round-robin. A master that keeps requesting waits at most MASTERS-1 grants.
- Requests changing in the same cycle as the grant decision are sampled as they are on that edge.
- The addr/cmd/wdata of the granted master are not latched; the master must hold them stable until ack.
- Reset asserted mid-transaction drops s_req asynchronously. The in-flight transaction is lost and no ack is forwarded.

Optional Feature:
- Macro: XBAR_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle without s_ack.
  - When the count reaches TIMEOUT-1 without an ack:
    - Force IDLE next cycle and set ptr=g.
    - Pulse timeout_err for 1 cycle.
    - No m_ack is driven.
- Undefined: no counter is built, timeout_err is tied 0, and BUSY waits indefinitely.

Test Plan:
- Single master: m_req[0]=1, m_addr[0]=32'h0000_0010, cmd=0, slave acks 2 cycles later with s_rdata=32'hAAAAAAAA.
  - Expect s_req 1 cycle after m_req, s_addr=32'h0000_0010.
  - Expect m_ack[0] pulse with m_rdata[0]=32'hAAAAAAAA.
  - Expect m_ack[1]=0 and m_rdata[1]=0.
- Decode filter on instance with SLAVE_ID=0: m_req[1]=1, m_addr[1]=32'h8000_0004.
  - Expect s_req to stay 0 and grant=0 for 10 cycles.
- Contention: both masters request continuously, both writes, wdata 32'h11111111 and 32'h22222222, zero-wait ack.
  - Expect grants in the order 01, 10, 01, 10, with s_wdata matching the granted master.
  - Expect s_req low for 1 cycle between transactions.
- Abort: master 1 granted, drops m_req before ack.
  - Expect IDLE next cycle, no m_ack.
  - Expect the next simultaneous request to still pick master 1, since ptr is unchanged.
- Reset mid-transaction: rst=0 while BUSY with s_ack=0.
  - Expect s_req, grant and m_ack at 0 immediately.
  - After release, a request from master 1 alone is granted, then master 0 wins the next tie.
- With XBAR_ARB_TIMEOUT_EN and TIMEOUT=4: grant master 0 and never ack.
  - Expect s_req high 4 cycles, then timeout_err pulses 1 cycle, then IDLE.
  - Expect master 1 to win the next tie.
